// File: rtl/usb_tx_framer_if.sv
// Byte-level link between the framer, the TX data FIFO and the downstream serializer.
// The master modport is the environment side; the slave modport is the framer side.
interface usb_tx_framer_if #(
  parameter int unsigned OCC_W = 7
);
  logic [7:0]       tx_packet_data;
  logic [OCC_W-1:0] buffer_occupancy;
  logic             get_tx_data;
  logic [7:0]       shift_data;
  logic             is_eop;
  logic             byte_ready;

  modport master (
    output tx_packet_data, buffer_occupancy, byte_ready,
    input  get_tx_data, shift_data, is_eop
  );

  modport slave (
    input  tx_packet_data, buffer_occupancy, byte_ready,
    output get_tx_data, shift_data, is_eop
  );
endinterface

// File: rtl/usb_tx_framer.sv
// USB transmit packet framer: SYNC, PID, payload, CRC16 and EOP bytes, one byte per serializer handshake.
// Define USB_TX_CRC_EN to generate the CRC16 bytes; without it packets go from PID/payload straight to EOP.
module usb_tx_framer #(
  parameter int unsigned SYNC_BYTES  = 1,
  parameter int unsigned MAX_PAYLOAD = 64,
  parameter int unsigned OCC_W       = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           begin_packet_i,
  input  logic [2:0]     tx_packet_i,
  usb_tx_framer_if.slave bus,
  output logic           end_packet_o,
  output logic           busy_o,
  output logic           pkt_err_o
);

  localparam int unsigned PAY_W     = $clog2(MAX_PAYLOAD + 1);
  localparam logic [1:0]  SYNC_LAST = 2'(SYNC_BYTES - 1);
  localparam logic [PAY_W-1:0] PAY_LAST = PAY_W'(MAX_PAYLOAD - 1);

  localparam logic [2:0] PT_DATA0 = 3'd1;
  localparam logic [2:0] PT_ACK   = 3'd2;
  localparam logic [2:0] PT_NAK   = 3'd3;
  localparam logic [2:0] PT_STALL = 3'd4;
  localparam logic [2:0] PT_DATA1 = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PID,
    S_DATA,
`ifdef USB_TX_CRC_EN
    S_CRC_LO,
    S_CRC_HI,
`endif
    S_EOP1,
    S_EOP2
  } state_e;

  // Where the packet goes once the payload (possibly empty) is finished
`ifdef USB_TX_CRC_EN
  localparam state_e S_POST_DATA = S_CRC_LO;
`else
  localparam state_e S_POST_DATA = S_EOP1;
`endif

  state_e           state_q, state_d;
  logic [2:0]       ptype_q, ptype_d;
  logic [1:0]       sync_cnt_q, sync_cnt_d;
  logic [PAY_W-1:0] pay_cnt_q, pay_cnt_d;
  logic             busy_q, end_packet_q, pkt_err_q, pkt_err_d;
  logic [7:0]       shift_data_c;
  logic             is_eop_c, get_tx_data_c;
  logic             legal_c, is_data_c;
  logic [7:0]       pid_c;

`ifdef USB_TX_CRC_EN
  logic [15:0] crc_q, crc_d;

  // Reflected USB CRC16 (x^16+x^15+x^2+1), data bits taken LSB first
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction
`endif

  always_comb begin
    legal_c   = (tx_packet_i >= PT_DATA0) && (tx_packet_i <= PT_DATA1);
    is_data_c = (ptype_q == PT_DATA0) || (ptype_q == PT_DATA1);
    case (ptype_q)
      PT_DATA0: pid_c = 8'hC3;
      PT_DATA1: pid_c = 8'h4B;
      PT_ACK:   pid_c = 8'hD2;
      PT_NAK:   pid_c = 8'h5A;
      PT_STALL: pid_c = 8'h1E;
      default:  pid_c = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptype_q      <= 3'd0;
      sync_cnt_q   <= 2'd0;
      pay_cnt_q    <= '0;
      busy_q       <= 1'b0;
      end_packet_q <= 1'b0;
      pkt_err_q    <= 1'b0;
`ifdef USB_TX_CRC_EN
      crc_q        <= 16'hFFFF;
`endif
    end else begin
      state_q      <= state_d;
      ptype_q      <= ptype_d;
      sync_cnt_q   <= sync_cnt_d;
      pay_cnt_q    <= pay_cnt_d;
      busy_q       <= (state_d != S_IDLE);
      end_packet_q <= (state_d == S_EOP2);
      pkt_err_q    <= pkt_err_d;
`ifdef USB_TX_CRC_EN
      crc_q        <= crc_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    ptype_d       = ptype_q;
    sync_cnt_d    = sync_cnt_q;
    pay_cnt_d     = pay_cnt_q;
    pkt_err_d     = 1'b0;
    shift_data_c  = 8'h00;
    is_eop_c      = 1'b0;
    get_tx_data_c = 1'b0;
`ifdef USB_TX_CRC_EN
    crc_d         = crc_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (begin_packet_i) begin
          if (legal_c) begin
            ptype_d    = tx_packet_i;
            sync_cnt_d = 2'd0;
            state_d    = S_SYNC;
          end else begin
            pkt_err_d = 1'b1;
          end
        end
      end
      S_SYNC: begin
        shift_data_c = (sync_cnt_q == SYNC_LAST) ? 8'h80 : 8'h00;
        if (bus.byte_ready) begin
          if (sync_cnt_q == SYNC_LAST) state_d = S_PID;
          else sync_cnt_d = sync_cnt_q + 2'd1;
        end
      end
      S_PID: begin
        shift_data_c = pid_c;
        if (bus.byte_ready) begin
          if (is_data_c) begin
            pay_cnt_d = '0;
`ifdef USB_TX_CRC_EN
            crc_d     = 16'hFFFF;
`endif
            state_d   = (bus.buffer_occupancy != '0) ? S_DATA : S_POST_DATA;
          end else begin
            state_d = S_EOP1;
          end
        end
      end
      S_DATA: begin
        shift_data_c  = bus.tx_packet_data;
        get_tx_data_c = bus.byte_ready;
        if (bus.byte_ready) begin
`ifdef USB_TX_CRC_EN
          crc_d     = crc16_step(crc_q, bus.tx_packet_data);
`endif
          pay_cnt_d = pay_cnt_q + PAY_W'(1);
          // Occupancy still counts the byte being popped this cycle
          if ((bus.buffer_occupancy <= OCC_W'(1)) || (pay_cnt_q == PAY_LAST)) state_d = S_POST_DATA;
        end
      end
`ifdef USB_TX_CRC_EN
      S_CRC_LO: begin
        shift_data_c = ~crc_q[7:0];
        if (bus.byte_ready) state_d = S_CRC_HI;
      end
      S_CRC_HI: begin
        shift_data_c = ~crc_q[15:8];
        if (bus.byte_ready) state_d = S_EOP1;
      end
`endif
      S_EOP1: begin
        shift_data_c = 8'hFC;
        is_eop_c     = 1'b1;
        state_d      = S_EOP2;
      end
      S_EOP2: begin
        shift_data_c = 8'hFC;
        is_eop_c     = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.shift_data  = shift_data_c;
  assign bus.is_eop      = is_eop_c;
  assign bus.get_tx_data = get_tx_data_c;
  assign busy_o          = busy_q;
  assign end_packet_o    = end_packet_q;
  assign pkt_err_o       = pkt_err_q;

endmodule

// File: tb/tb_usb_tx_framer.sv
// Self-checking bench for usb_tx_framer: an FS instance (1 SYNC byte, 4-byte payload cap) and an HS
// instance (4 SYNC bytes, 64-byte cap) share one FIFO model and serializer model; a scoreboard holds expected bytes.
module tb_usb_tx_framer;
  localparam int unsigned OCC_W  = 7;
  localparam int unsigned FS_MAX = 4;
  localparam int unsigned HS_MAX = 64;

  typedef struct packed {
    logic [7:0] b;
    logic       eop;
    logic       pop;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, begin_packet, byte_ready, sel_hs;
  logic [2:0]       tx_packet;
  logic [7:0]       head;
  logic [OCC_W-1:0] occ;
  logic             fs_end, fs_busy, fs_err, hs_end, hs_busy, hs_err;
  logic [7:0]       shift_data;
  logic             is_eop, get_tx, busy, end_pkt, pkt_err;

  logic [7:0] fifo[$];
  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  usb_tx_framer_if #(.OCC_W(OCC_W)) fs_if();
  usb_tx_framer_if #(.OCC_W(OCC_W)) hs_if();

  assign fs_if.tx_packet_data   = head;
  assign fs_if.buffer_occupancy = occ;
  assign fs_if.byte_ready       = byte_ready;
  assign hs_if.tx_packet_data   = head;
  assign hs_if.buffer_occupancy = occ;
  assign hs_if.byte_ready       = byte_ready;

  usb_tx_framer #(.SYNC_BYTES(1), .MAX_PAYLOAD(FS_MAX), .OCC_W(OCC_W)) u_fs (
    .clk(clk), .rst(rst), .begin_packet_i(begin_packet && !sel_hs), .tx_packet_i(tx_packet),
    .bus(fs_if.slave), .end_packet_o(fs_end), .busy_o(fs_busy), .pkt_err_o(fs_err)
  );

  usb_tx_framer #(.SYNC_BYTES(4), .MAX_PAYLOAD(HS_MAX), .OCC_W(OCC_W)) u_hs (
    .clk(clk), .rst(rst), .begin_packet_i(begin_packet && sel_hs), .tx_packet_i(tx_packet),
    .bus(hs_if.slave), .end_packet_o(hs_end), .busy_o(hs_busy), .pkt_err_o(hs_err)
  );

  assign shift_data = sel_hs ? hs_if.shift_data  : fs_if.shift_data;
  assign is_eop     = sel_hs ? hs_if.is_eop      : fs_if.is_eop;
  assign get_tx     = sel_hs ? hs_if.get_tx_data : fs_if.get_tx_data;
  assign busy       = sel_hs ? hs_busy : fs_busy;
  assign end_pkt    = sel_hs ? hs_end  : fs_end;
  assign pkt_err    = sel_hs ? hs_err  : fs_err;

  task automatic refresh_fifo();
    head = (fifo.size() > 0) ? fifo[0] : 8'h00;
    occ  = OCC_W'(fifo.size());
  endtask

  task automatic push_exp(input logic [7:0] b, input logic eop, input logic pop);
    exp_t e;
    e.b = b; e.eop = eop; e.pop = pop;
    exp_q.push_back(e);
  endtask

`ifdef USB_TX_CRC_EN
  // Non-reflected MSB-first CRC16 (poly 8005) fed with each byte's bits LSB first
  function automatic logic [15:0] crc_n_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] n;
    logic        fb;
    n = c;
    for (int i = 0; i < 8; i++) begin
      fb = n[15] ^ d[i];
      n  = {n[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return n;
  endfunction
`endif

  // Sends one packet through the selected instance and checks every byte against the scoreboard
  task automatic run_packet(input logic hs, input logic [2:0] ptype, input logic scramble);
    int unsigned sync_n, maxp, npay, pops_seen, cycles;
    logic        is_data, pending_pop, done;
    logic [7:0]  pid;
    exp_t        e;
`ifdef USB_TX_CRC_EN
    logic [15:0] crc_n, crc_r;
`endif
    sync_n  = hs ? 4 : 1;
    maxp    = hs ? HS_MAX : FS_MAX;
    is_data = (ptype == 3'd1) || (ptype == 3'd5);
    case (ptype)
      3'd1:    pid = 8'hC3;
      3'd2:    pid = 8'hD2;
      3'd3:    pid = 8'h5A;
      3'd4:    pid = 8'h1E;
      default: pid = 8'h4B;
    endcase
    exp_q.delete();
    for (int i = 0; i < int'(sync_n); i++) push_exp((i == int'(sync_n) - 1) ? 8'h80 : 8'h00, 1'b0, 1'b0);
    push_exp(pid, 1'b0, 1'b0);
    npay = 0;
    if (is_data) npay = (fifo.size() < int'(maxp)) ? fifo.size() : maxp;
`ifdef USB_TX_CRC_EN
    crc_n = 16'hFFFF;
`endif
    for (int k = 0; k < int'(npay); k++) begin
      push_exp(fifo[k], 1'b0, 1'b1);
`ifdef USB_TX_CRC_EN
      crc_n = crc_n_byte(crc_n, fifo[k]);
`endif
    end
`ifdef USB_TX_CRC_EN
    if (is_data) begin
      for (int i = 0; i < 16; i++) crc_r[i] = crc_n[15-i];
      push_exp(~crc_r[7:0], 1'b0, 1'b0);
      push_exp(~crc_r[15:8], 1'b0, 1'b0);
    end
`endif
    push_exp(8'hFC, 1'b1, 1'b0);
    push_exp(8'hFC, 1'b1, 1'b0);

    sel_hs = hs;
    @(negedge clk);
    tx_packet = ptype; begin_packet = 1'b1; byte_ready = 1'b0;
    @(negedge clk);
    begin_packet = 1'b0;
    if (scramble) tx_packet = 3'($urandom_range(0, 7));
    pending_pop = 1'b0; done = 1'b0; cycles = 0; pops_seen = 0;
    while (!done && cycles < 600) begin
      if (pending_pop) begin
        void'(fifo.pop_front());
        refresh_fifo();
        pending_pop = 1'b0;
      end
      byte_ready   = ($urandom_range(0, 3) != 0);
      begin_packet = scramble && ($urandom_range(0, 7) == 0);
      #1;
      if (get_tx) begin
        pops_seen++;
        pending_pop = 1'b1;
      end
      if (busy !== 1'b1) begin
        n_tests++; n_fail++; done = 1'b1;
        $display("FAIL unexpected_idle busy=%b, required 1 (%0d bytes outstanding)", busy, exp_q.size());
      end else if (is_eop === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++; done = 1'b1;
          $display("FAIL extra_eop shift=%h with empty scoreboard", shift_data);
        end else begin
          e = exp_q.pop_front();
          n_tests++;
          if (shift_data !== e.b || e.eop !== 1'b1) begin
            n_fail++;
            $display("FAIL eop_byte got %h eop=1, required %h eop=%b", shift_data, e.b, e.eop);
          end
          n_tests++;
          if (end_pkt !== (exp_q.size() == 0)) begin
            n_fail++;
            $display("FAIL end_packet got %b, required %b", end_pkt, (exp_q.size() == 0));
          end
          if (exp_q.size() == 0) done = 1'b1;
        end
      end else begin
        n_tests++;
        if (end_pkt !== 1'b0) begin
          n_fail++;
          $display("FAIL end_packet_outside_eop got %b, required 0", end_pkt);
        end
        if (byte_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++; done = 1'b1;
            $display("FAIL extra_byte got %h with empty scoreboard", shift_data);
          end else begin
            e = exp_q.pop_front();
            n_tests++;
            if (shift_data !== e.b || e.eop !== 1'b0) begin
              n_fail++;
              $display("FAIL byte got %h eop=0, required %h eop=%b", shift_data, e.b, e.eop);
            end
            n_tests++;
            if (get_tx !== e.pop) begin
              n_fail++;
              $display("FAIL get_tx_data got %b on byte %h, required %b", get_tx, shift_data, e.pop);
            end
          end
        end
      end
      @(negedge clk);
      cycles++;
    end
    begin_packet = 1'b0;
    byte_ready   = 1'b0;
    if (pending_pop) begin
      void'(fifo.pop_front());
      refresh_fifo();
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL packet_timeout after %0d cycles, %0d bytes outstanding", cycles, exp_q.size());
    end
    n_tests++;
    if (pops_seen != npay) begin
      n_fail++;
      $display("FAIL pop_count got %0d, required %0d", pops_seen, npay);
    end
    #1;
    n_tests++;
    if (busy !== 1'b0 || is_eop !== 1'b0 || shift_data !== 8'h00 || end_pkt !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after busy=%b eop=%b shift=%h end=%b, required 0 0 00 0", busy, is_eop, shift_data, end_pkt);
    end
  endtask

  task automatic test_reset();
    int unsigned pops;
    logic        pend;
    rst = 1'b1; begin_packet = 1'b0; byte_ready = 1'b0; tx_packet = 3'd0; sel_hs = 1'b0;
    fifo.delete(); refresh_fifo();
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel_hs = (s == 1);
      #1;
      n_tests++;
      if (busy !== 0 || is_eop !== 0 || shift_data !== 8'h00 || end_pkt !== 0 || pkt_err !== 0 || get_tx !== 0) begin
        n_fail++;
        $display("FAIL reset_state inst=%0d busy=%b eop=%b shift=%h end=%b err=%b get=%b, required all 0",
                 s, busy, is_eop, shift_data, end_pkt, pkt_err, get_tx);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) fifo.push_back(8'(8'h10 + i));
    refresh_fifo();
    sel_hs = 1'b1; pops = 0; pend = 1'b0;
    tx_packet = 3'd1; begin_packet = 1'b1;
    @(negedge clk);
    begin_packet = 1'b0; byte_ready = 1'b1;
    // Four SYNC bytes, the PID, then two DATA bytes before the abort
    for (int i = 1; i <= 7; i++) begin
      #1;
      if (get_tx) begin pops++; pend = 1'b1; end
      if (i < 7) begin
        @(negedge clk);
        if (pend) begin void'(fifo.pop_front()); refresh_fifo(); pend = 1'b0; end
      end
    end
    n_tests++;
    if (pops != 2) begin
      n_fail++;
      $display("FAIL reset_reached_data pops=%0d, required 2", pops);
    end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b0;
      #1;
      n_tests++;
      if (busy !== 0 || is_eop !== 0 || shift_data !== 8'h00 || end_pkt !== 0 || get_tx !== 0) begin
        n_fail++;
        $display("FAIL reset_abort cyc=%0d busy=%b eop=%b shift=%h end=%b get=%b, required all 0",
                 i, busy, is_eop, shift_data, end_pkt, get_tx);
      end
    end
    byte_ready = 1'b0;
    fifo.delete(); refresh_fifo();
  endtask

  task automatic test_handshake();
    run_packet(1'b0, 3'd2, 1'b0);
    run_packet(1'b1, 3'd4, 1'b0);
  endtask

  task automatic test_data1_single();
    fifo.delete(); fifo.push_back(8'hA5); refresh_fifo();
    run_packet(1'b1, 3'd5, 1'b0);
    n_tests++;
    if (fifo.size() != 0) begin
      n_fail++;
      $display("FAIL data1_fifo_left got %0d, required 0", fifo.size());
    end
  endtask

  task automatic test_zero_length();
    fifo.delete(); refresh_fifo();
    run_packet(1'b0, 3'd1, 1'b0);
    run_packet(1'b1, 3'd5, 1'b0);
  endtask

  task automatic test_max_payload();
    fifo.delete();
    for (int i = 0; i < 10; i++) fifo.push_back(8'($urandom_range(0, 255)));
    refresh_fifo();
    run_packet(1'b0, 3'd1, 1'b0);
    n_tests++;
    if (fifo.size() != 6) begin
      n_fail++;
      $display("FAIL fs_cap_fifo_left got %0d, required 6", fifo.size());
    end
    fifo.delete();
    for (int i = 0; i < 70; i++) fifo.push_back(8'($urandom_range(0, 255)));
    refresh_fifo();
    run_packet(1'b1, 3'd5, 1'b0);
    n_tests++;
    if (fifo.size() != 6) begin
      n_fail++;
      $display("FAIL hs_cap_fifo_left got %0d, required 6", fifo.size());
    end
    fifo.delete(); refresh_fifo();
  endtask

  task automatic test_illegal();
    logic [2:0] code;
    sel_hs = 1'b0;
    for (int k = 0; k < 3; k++) begin
      code = (k == 0) ? 3'd6 : ((k == 1) ? 3'd0 : 3'd7);
      @(negedge clk);
      tx_packet = code; begin_packet = 1'b1;
      @(negedge clk);
      begin_packet = 1'b0;
      #1;
      n_tests++;
      if (pkt_err !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_pulse code=%0d err=%b busy=%b, required 1 0", code, pkt_err, busy);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (pkt_err !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_clear code=%0d err=%b busy=%b, required 0 0", code, pkt_err, busy);
      end
    end
    run_packet(1'b0, 3'd3, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [2:0] t;
    int unsigned n;
    for (int p = 0; p < 8; p++) begin
      fifo.delete();
      n = $urandom_range(0, 20);
      for (int i = 0; i < int'(n); i++) fifo.push_back(8'($urandom_range(0, 255)));
      refresh_fifo();
      t = 3'($urandom_range(1, 5));
      run_packet(p[0], t, 1'b1);
    end
    fifo.delete(); refresh_fifo();
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_data1_single();
    test_zero_length();
    test_max_payload();
    test_illegal();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
